// File: rtl/pet2001_uart_pkg.sv
// Shared types and constants for the PET 2001 cassette-over-serial UART.
package pet2001_uart_pkg;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/pet2001_uart232_bit_timer.sv
// Loadable down-counter that paces one bit period (or a fraction of one).
// 'expire' is high for the single cycle in which the count sits at 1, so the
// owner acts on the following edge, exactly load_value cycles after loading.
module uart_bit_timer
    import pet2001_uart_pkg::*;
#(
    parameter int CTR_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [CTR_W-1:0] load_value,
    output logic             expire
);

    logic [CTR_W-1:0] count;

    // Load has priority over counting; the count parks at zero when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - CTR_W'(1);
        end
    end

    assign expire = enable && (count == CTR_W'(1));

endmodule

// File: rtl/pet2001_uart232.sv
// 8N1 RS-232 UART between the PET cassette shifter/FIFO and the serial pins.
// TX and RX are completely independent halves sharing only clock and reset.
module pet2001_uart232
    import pet2001_uart_pkg::*;
#(
    parameter int CLK_DIVIDER = 1302,
    parameter int CTR_W       = 12
) (
    input  logic       clk,
    input  logic       reset,
    output logic       serial_out,
    input  logic       serial_in,
    output logic       write_rdy,
    input  logic [7:0] write_data,
    input  logic       write_strobe,
    output logic [7:0] read_data,
    output logic       read_strobe,
    output logic       frame_err
);

    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [CTR_W-1:0] FULL_BIT  = CTR_W'(CLK_DIVIDER);
    localparam logic [CTR_W-1:0] HALF_BIT  = CTR_W'(CLK_DIVIDER / 2);

    // ---------------- transmitter ----------------
    tx_state_t  tx_state;
    logic [7:0] tx_shift;
    logic [2:0] tx_bit_cnt;
    logic       tx_capture;
    logic       tx_load;
    logic       tx_expire;

    assign tx_capture = (tx_state == TX_IDLE) && write_strobe && write_rdy;
    assign tx_load    = tx_capture || (tx_expire && (tx_state != TX_STOP));

    uart_bit_timer #(.CTR_W(CTR_W)) u_tx_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tx_load),
        .enable     (tx_state != TX_IDLE),
        .load_value (FULL_BIT),
        .expire     (tx_expire)
    );

    // TX framing FSM: serial_out is registered so each bit lasts one full period.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            tx_shift   <= '0;
            tx_bit_cnt <= '0;
            serial_out <= 1'b1;
            write_rdy  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_capture) begin
                        tx_shift   <= write_data;
                        serial_out <= 1'b0;
                        write_rdy  <= 1'b0;
                        tx_state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_expire) begin
                        serial_out <= tx_shift[0];
                        tx_shift   <= {1'b0, tx_shift[7:1]};
                        tx_bit_cnt <= '0;
                        tx_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_expire) begin
                        if (tx_bit_cnt == LAST_BIT) begin
                            serial_out <= 1'b1;
                            tx_state   <= TX_STOP;
                        end else begin
                            serial_out <= tx_shift[0];
                            tx_shift   <= {1'b0, tx_shift[7:1]};
                        end
                        tx_bit_cnt <= tx_bit_cnt + 3'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_expire) begin
                        write_rdy <= 1'b1;
                        tx_state  <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   rx_s;
    rx_state_t              rx_state;
    logic [7:0]             rx_shift;
    logic [2:0]             rx_bit_cnt;
    logic                   rx_load;
    logic [CTR_W-1:0]       rx_load_value;
    logic                   rx_expire;
    logic                   rx_timing;

    // Two-flop synchroniser; the line idles high so the flops reset high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync <= '1;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], serial_in};
        end
    end

    assign rx_s      = rx_sync[SYNC_STAGES-1];
    assign rx_timing = (rx_state == RX_START) || (rx_state == RX_DATA) ||
                       (rx_state == RX_STOP);

    // Half a period to the middle of the start bit, then full periods per bit.
    always_comb begin
        rx_load       = 1'b0;
        rx_load_value = FULL_BIT;
        case (rx_state)
            RX_IDLE: begin
                rx_load       = !rx_s;
                rx_load_value = HALF_BIT;
            end
            RX_START: rx_load = rx_expire && !rx_s;
            RX_DATA:  rx_load = rx_expire;
            default:  rx_load = 1'b0;
        endcase
    end

    uart_bit_timer #(.CTR_W(CTR_W)) u_rx_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (rx_load),
        .enable     (rx_timing),
        .load_value (rx_load_value),
        .expire     (rx_expire)
    );

    // RX framing FSM: samples mid-bit, reports good bytes or a one-shot framing error.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state    <= RX_IDLE;
            rx_shift    <= '0;
            rx_bit_cnt  <= '0;
            read_data   <= '0;
            read_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            read_strobe <= 1'b0;
            frame_err   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_expire) begin
                        if (rx_s) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_bit_cnt <= '0;
                            rx_state   <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_expire) begin
                        rx_shift   <= {rx_s, rx_shift[7:1]};
                        rx_bit_cnt <= rx_bit_cnt + 3'd1;
                        if (rx_bit_cnt == LAST_BIT) begin
                            rx_state <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_expire) begin
                        if (rx_s) begin
                            read_data   <= rx_shift;
                            read_strobe <= 1'b1;
                            rx_state    <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            rx_state  <= RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_s) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pet2001_uart232.md
Name: pet2001_uart232

Overview:
- 8N1 RS-232 UART for the PET cassette-over-serial path, sitting directly between the serial pins (tx232/rx232) and the cassette sampling/FIFO logic.
- TX side: accepts one byte per strobe from the cassette-write shifter and serialises it.
- RX side: deserialises incoming bytes and emits a one-cycle strobe that writes them into the receive FIFO.
- Runs at 38,400 baud from the 50 MHz system clock.

Parameters:
- CLK_DIVIDER, 1302, clocks per bit period; must be >= 8.
- CTR_W, 12, width of the bit-period counters; must satisfy 2^CTR_W > CLK_DIVIDER.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- serial_out  out  1  TX line; idles high.
- serial_in  in  1  RX line; asynchronous to clk.
- write_rdy  out  1  high when the transmitter can accept a byte.
- write_data  in  8  byte to transmit; sampled on write_strobe.
- write_strobe  in  1  one-cycle request to send write_data.
- read_data  out  8  last correctly framed received byte.
- read_strobe  out  1  one-cycle pulse when read_data is updated.
- frame_err  out  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset values:
  - serial_out=1, write_rdy=1, read_data=8'h00, read_strobe=0, frame_err=0.
  - Both synchroniser flops=1; both FSMs in IDLE; counters=0.
- Reset asserted mid-frame aborts either side immediately. serial_out returns high on the next clock.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: on write_strobe && write_rdy:
  - latch write_data into the shift register;
  - write_rdy=0 from the next cycle;
  - enter START.
- write_strobe while write_rdy=0 is ignored; the in-flight byte is not corrupted.
- START: serial_out=0 for exactly CLK_DIVIDER cycles.
- DATA: 8 bits, LSB first, each held CLK_DIVIDER cycles. A 3-bit bit counter wraps 7->0 on exit.
- STOP: serial_out=1 for CLK_DIVIDER cycles, then IDLE with write_rdy=1 on the same edge.
- Frame length: 10*CLK_DIVIDER cycles from the strobe-capture edge to write_rdy rising.
- Back-to-back: a strobe in the first cycle write_rdy=1 starts a new start bit with no extra idle gap.

RX path:
- serial_in passes through a 2-flop synchroniser; rx_s is the second flop. Everything below uses rx_s only.
- RX FSM (IDLE, START, DATA, STOP, BREAK):
  - IDLE: rx_s==0 loads the counter with CLK_DIVIDER/2 (integer divide) and enters START.
  - START: when the counter expires, resample rx_s.
    - rx_s==1: glitch; return to IDLE with no outputs.
    - rx_s==0: reload CLK_DIVIDER and enter DATA.
  - DATA: on each expiry, shift rx_s into bit 7 (LSB arrives first) and reload. After the 8th sample, enter STOP.
  - STOP: on expiry, sample rx_s.
    - rx_s==1: read_data <= shift register and read_strobe=1 on the next cycle; go to IDLE.
    - rx_s==0: frame_err=1 for one cycle; read_data is unchanged and there is no read_strobe; go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. Prevents a held-low line from producing repeated frames.
- Latency: read_strobe rises CLK_DIVIDER/2 + 9*CLK_DIVIDER + 3 cycles after the falling edge at the serial_in pin (2 synchroniser cycles + 1 output register).
- read_strobe and frame_err are never high in the same cycle. Each is high for at most one cycle per frame.
- TX and RX are fully independent; simultaneous activity is required to work.

Decomposition:
- Package pet2001_uart_pkg:
  - tx_state_t (IDLE/START/DATA/STOP);
  - rx_state_t (IDLE/START/DATA/STOP/BREAK);
  - localparams DATA_BITS=8, SYNC_STAGES=2.
- One sub-module, uart_bit_timer:
  - loadable down-counter, width CTR_W, with load value and enable inputs;
  - 'expire' output is a one-cycle pulse when the count reaches 1;
  - instantiated once for TX and once for RX.

Test Plan (CLK_DIVIDER=16 for simulation):
1. TX 8'hA5 via single strobe:
   - serial_out reads 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles;
   - write_rdy is low exactly 160 cycles.
2. Two strobes 1 cycle apart (second while write_rdy=0):
   - only the first byte is transmitted;
   - the second is ignored and the line is idle after 160 cycles.
3. RX frame 8'h3C driven on serial_in at 16 cycles/bit with a valid stop bit:
   - a single read_strobe with read_data=8'h3C, 8+144+3=155 cycles after the start edge;
   - frame_err stays 0.
4. serial_in low for 5 cycles, then high:
   - no read_strobe, no frame_err;
   - FSM back in IDLE and accepts a following 8'h81 frame correctly.
5. RX 8'h55 with stop bit driven 0, then line held low 100 cycles, then high and a frame 8'h12:
   - one frame_err pulse and read_data stays at its prior value;
   - no further events while low;
   - then read_strobe with read_data=8'h12.
6. Reset asserted mid-TX (bit 4) and mid-RX:
   - next cycle serial_out=1 and write_rdy=1;
   - no read_strobe;
   - a subsequent full-duplex TX 8'hFF / RX 8'h00 exchange completes correctly.
